fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_if.sv | 37 +++
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage control, imem and IF/ID signals; counters exist only with PERF_CNT_EN
interface fetch_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
`ifdef PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
  logic [31:0] RetireCnt;
`endif
  modport master (
`ifdef PERF_CNT_EN
    input  StallCnt, FlushCnt, RetireCnt,
`endif
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, ALUResultE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD
  );
  modport slave (
`ifdef PERF_CNT_EN
    output StallCnt, FlushCnt, RetireCnt,
`endif
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, ALUResultE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register; PERF_CNT_EN adds stall/flush/retire counters
module fetch_stage (
  input logic   clk,
  input logic   rst,
  fetch_if.slave f
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    pc_d    = f.PCSrcE == 2'b00 ? (f.StallF ? pc_q : pc_plus4) :
              f.PCSrcE == 2'b10 ? {f.ALUResultE[31:1], 1'b0} : f.PCTargetE;
    instr_d = f.FlushD ? NOP   : f.StallD ? instr_q : f.InstrF;
    pcd_d   = f.FlushD ? 32'd0 : f.StallD ? pcd_q   : pc_q;
    pcp4_d  = f.FlushD ? 32'd0 : f.StallD ? pcp4_q  : pc_plus4;
    valid_d = f.FlushD ? 1'b0  : f.StallD ? valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'd0;
      instr_q <= NOP;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end
  assign f.PCF      = pc_q;
  assign f.InstrD   = instr_q;
  assign f.PCD      = pcd_q;
  assign f.PCPlus4D = pcp4_q;
  assign f.ValidD   = valid_q;
  assign f.Rs1D     = instr_q[19:15];
  assign f.Rs2D     = instr_q[24:20];
  assign f.RdD      = instr_q[11:7];
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, retire_cnt_q, retire_cnt_d;
  always_comb begin
    stall_cnt_d  = stall_cnt_q  + {31'd0, f.StallF && f.PCSrcE == 2'b00};
    flush_cnt_d  = flush_cnt_q  + {31'd0, f.FlushD};
    retire_cnt_d = retire_cnt_q + {31'd0, !f.FlushD && !f.StallD};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
  assign f.StallCnt  = stall_cnt_q;
  assign f.FlushCnt  = flush_cnt_q;
  assign f.RetireCnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;
  logic [31:0] seed = 32'd0;

  fetch_if f ();
  fetch_stage dut (.clk(clk), .rst(rst), .f(f));

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ seed;
  endfunction

  assign f.InstrF = imem(f.PCF);

  logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_sc, m_fc, m_rc;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] npc;
    if (rst) begin
      m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_rc = 0;
    end else begin
      case (f.PCSrcE)
        2'd0:    npc = f.StallF ? m_pc : m_pc + 4;
        2'd2:    npc = f.ALUResultE & ~32'd1;
        default: npc = f.PCTargetE;
      endcase
      if (f.StallF && f.PCSrcE == 2'd0) m_sc = m_sc + 1;
      if (f.FlushD) begin
        m_fc = m_fc + 1;
        m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0;
      end else if (!f.StallD) begin
        m_rc = m_rc + 1;
        m_instr = imem(m_pc); m_pcd = m_pc; m_p4 = m_pc + 4; m_valid = 1;
      end
      m_pc = npc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("PCF", f.PCF, m_pc);
    chk("InstrD", f.InstrD, m_instr);
    chk("PCD", f.PCD, m_pcd);
    chk("PCPlus4D", f.PCPlus4D, m_p4);
    chk("ValidD", {31'd0, f.ValidD}, {31'd0, m_valid});
    chk("Rs1D", {27'd0, f.Rs1D}, {27'd0, m_instr[19:15]});
    chk("Rs2D", {27'd0, f.Rs2D}, {27'd0, m_instr[24:20]});
    chk("RdD", {27'd0, f.RdD}, {27'd0, m_instr[11:7]});
`ifdef PERF_CNT_EN
    chk("StallCnt", f.StallCnt, m_sc);
    chk("FlushCnt", f.FlushCnt, m_fc);
    chk("RetireCnt", f.RetireCnt, m_rc);
`endif
  end

  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    rst = r; f.StallF = sf; f.StallD = sd; f.FlushD = fd;
    f.PCSrcE = src; f.PCTargetE = tgt; f.ALUResultE = alu;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    cmp_en = 1'b1;
    chk("rst PCF", f.PCF, 0);
    chk("rst InstrD", f.InstrD, 32'h13);
    chk("rst ValidD", {31'd0, f.ValidD}, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("run1 PCF", f.PCF, 4);
    chk("run1 InstrD", f.InstrD, 0);
    chk("run1 ValidD", {31'd0, f.ValidD}, 1);
    chk("run1 PCPlus4D", f.PCPlus4D, 4);
    tick();
    chk("run2 PCF", f.PCF, 8);
    chk("run2 InstrD", f.InstrD, 1);
    tick();
    chk("run3 PCF", f.PCF, 12);
    chk("run3 InstrD", f.InstrD, 2);
    tick();
    chk("run4 PCF", f.PCF, 32'h10);
    chk("run4 InstrD", f.InstrD, 3);
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall PCF", f.PCF, 32'h10);
      chk("stall InstrD", f.InstrD, 3);
    end
`ifdef PERF_CNT_EN
    chk("stall StallCnt", f.StallCnt, 2);
    chk("stall RetireCnt", f.RetireCnt, 4);
`endif
    drive(0, 0, 0, 1, 2'b01, 32'h40, 0);
    tick();
    chk("br PCF", f.PCF, 32'h40);
    chk("br InstrD", f.InstrD, 32'h13);
    chk("br ValidD", {31'd0, f.ValidD}, 0);
`ifdef PERF_CNT_EN
    chk("br FlushCnt", f.FlushCnt, 1);
`endif
    drive(0, 1, 1, 1, 2'b10, 0, 32'h83);
    tick();
    chk("jalr PCF", f.PCF, 32'h82);
    chk("jalr InstrD", f.InstrD, 32'h13);
    chk("jalr PCD", f.PCD, 0);
    drive(0, 0, 0, 0, 2'b01, 32'hFFFF_FFFC, 0);
    tick();
    chk("wrap PCF0", f.PCF, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap PCF", f.PCF, 0);
    chk("wrap PCPlus4D", f.PCPlus4D, 0);
    chk("wrap PCD", f.PCD, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 2'b01, 32'h40, 0);
    tick();
    chk("mrst PCF", f.PCF, 0);
    chk("mrst ValidD", {31'd0, f.ValidD}, 0);
`ifdef PERF_CNT_EN
    chk("mrst StallCnt", f.StallCnt, 0);
    chk("mrst FlushCnt", f.FlushCnt, 0);
    chk("mrst RetireCnt", f.RetireCnt, 0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("resume PCF", f.PCF, 4);
    chk("resume InstrD", f.InstrD, 0);
    seed = $urandom;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
            tgt, $urandom);
      tick();
    end
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
